pc_fetch_ctrl: RTL and testbench
================================

Name: pc_fetch_ctrl

Overview:
Program-counter and fetch-control stage sitting directly upstream of the instruction memory. Drives the word-aligned fetch address A_PC; the memory returns INSTR combinationally in the same cycle. Each cycle it selects the next PC from sequential, branch/jump target or hold (stall). A small FSM detects the all-zero end-of-program word (halt) and illegal fetch targets (fault).

Parameters:
pc_width, 32, width of PC and target addresses
reg_width, 32, instruction word width
depth, 64, instruction memory depth in words; legal fetch range is 0 .. depth*4-4
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
CLK  input  1  system clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
INSTR  input  reg_width  instruction word returned by instruction memory for current A_PC
PC_SRC  input  1  1 = take PC_TARGET this cycle (taken branch / JAL / JALR)
PC_TARGET  input  pc_width  next-PC target from branch/jump logic
STALL  input  1  1 = hold PC this cycle
A_PC  output  pc_width  current fetch address to instruction memory (registered)
PC_PLUS4  output  pc_width  A_PC+4, combinational, link value for JAL/JALR
HALTED  output  1  end-of-program reached (sticky)
FAULT  output  1  illegal fetch target (sticky)
FAULT_ADDR  output  pc_width  offending address captured on fault
RETIRED  output  32  instructions retired counter (see Optional Feature)
CYCLES  output  32  cycles in RUN state counter (see Optional Feature)

Behaviour:
- Clock CLK; reset RST is synchronous and active-high, sampled on CLK rising edge, overrides every other input and every state including HALT and FAULT.
- Reset values: A_PC=RESET_PC, state=RUN, HALTED=0, FAULT=0, FAULT_ADDR=0, RETIRED=0, CYCLES=0.
- States: RUN, HALT, FAULT. HALT and FAULT exit only via RST.
- RUN, per-cycle priority (highest first):
  1. STALL=1 -> A_PC holds; no halt/fault evaluation; RETIRED holds.
  2. INSTR==0 -> go HALT; A_PC holds; zero word not retired.
  3. PC_SRC=1 -> if PC_TARGET[1:0]!=0 or PC_TARGET>depth*4-4: go FAULT, FAULT_ADDR<=PC_TARGET, A_PC holds. Else A_PC<=PC_TARGET, RETIRED+1.
  4. otherwise -> if A_PC+4>depth*4-4: go FAULT, FAULT_ADDR<=A_PC+4, A_PC holds. Else A_PC<=A_PC+4, RETIRED+1.
- Latency: next PC visible on A_PC one cycle after decision; INSTR for it valid same cycle (zero-latency memory).
- HALT: HALTED=1, A_PC frozen, PC_SRC/STALL/INSTR ignored.
- FAULT: FAULT=1, A_PC frozen at last legal PC, FAULT_ADDR frozen.
- HALTED and FAULT never both 1.
- CYCLES increments every cycle in RUN (stalled cycles included), holds otherwise.
- Arithmetic: PC_PLUS4 and A_PC+4 computed modulo 2^pc_width; range checks use full-width unsigned compare, so wrap past 2^pc_width is caught as fault.
- Counters wrap modulo 2^32 silently.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: RETIRED and CYCLES counters implemented as above.
- Not defined: counter registers absent; RETIRED and CYCLES tied to 0; all other behaviour identical.

Test Plan:
- RST=1 for 2 cycles, then INSTR=32'h00000093 constant, PC_SRC=0 -> A_PC 0,4,8,12 on successive cycles; RETIRED=3 after third advance (FETCH_PERF_CNT_EN defined).
- At A_PC=8 drive PC_SRC=1, PC_TARGET=32'h20 -> next cycle A_PC=32'h20; PC_TARGET=32'h22 instead -> FAULT=1, FAULT_ADDR=32'h22, A_PC stays 8.
- STALL=1 for 3 cycles at A_PC=32'h10 with INSTR=0 -> A_PC stays 32'h10, HALTED=0, CYCLES +3; STALL drops -> HALTED=1 next cycle, A_PC stays 32'h10.
- depth=64, sequential from A_PC=32'hFC -> FAULT=1, FAULT_ADDR=32'h100, A_PC=32'hFC; PC_TARGET=32'h100 with PC_SRC=1 likewise faults.
- In HALT, toggle PC_SRC/STALL/INSTR for 10 cycles -> A_PC, HALTED, counters unchanged; assert RST one cycle -> A_PC=RESET_PC, HALTED=0, RETIRED=0 next cycle.
- Build without FETCH_PERF_CNT_EN, rerun first scenario -> identical A_PC sequence, RETIRED=0 and CYCLES=0 throughout.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle between the PC/fetch control stage and its neighbours:
// instruction memory data, branch redirect, stall, and fetch status outputs.
interface pc_fetch_ctrl_if #(
    parameter int pc_width  = 32,
    parameter int reg_width = 32
);
    logic [reg_width-1:0] INSTR;
    logic                 PC_SRC;
    logic [pc_width-1:0]  PC_TARGET;
    logic                 STALL;
    logic [pc_width-1:0]  A_PC;
    logic [pc_width-1:0]  PC_PLUS4;
    logic                 HALTED;
    logic                 FAULT;
    logic [pc_width-1:0]  FAULT_ADDR;
    logic [31:0]          RETIRED;
    logic [31:0]          CYCLES;

    modport master (
        output INSTR,
        output PC_SRC,
        output PC_TARGET,
        output STALL,
        input  A_PC,
        input  PC_PLUS4,
        input  HALTED,
        input  FAULT,
        input  FAULT_ADDR,
        input  RETIRED,
        input  CYCLES
    );

    modport slave (
        input  INSTR,
        input  PC_SRC,
        input  PC_TARGET,
        input  STALL,
        output A_PC,
        output PC_PLUS4,
        output HALTED,
        output FAULT,
        output FAULT_ADDR,
        output RETIRED,
        output CYCLES
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC / fetch control with halt-on-zero-word and illegal-target fault FSM.
// Define FETCH_PERF_CNT_EN to build the RETIRED / CYCLES counters.
module pc_fetch_ctrl #(
    parameter int                 pc_width  = 32,
    parameter int                 reg_width = 32,
    parameter int                 depth     = 64,
    parameter logic [pc_width-1:0] RESET_PC = '0
) (
    input  logic           CLK,
    input  logic           RST,
    pc_fetch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    // One extra bit so a sequential step past the top of the address
    // space is seen as out of range rather than wrapping to a legal PC.
    localparam logic [pc_width:0] LAST_PC = (pc_width + 1)'(depth * 4 - 4);

    state_t              state;
    logic [pc_width-1:0] a_pc;
    logic                halted;
    logic                fault;
    logic [pc_width-1:0] fault_addr;

    logic [pc_width:0]   seq_wide;
    logic [pc_width-1:0] pc_plus4;
    logic                seq_bad;
    logic                tgt_bad;
    logic                instr_zero;

    logic                do_hold;
    logic                do_halt;
    logic                do_jump;
    logic                do_seq;

    assign seq_wide   = {1'b0, a_pc} + (pc_width + 1)'(4);
    assign pc_plus4   = seq_wide[pc_width-1:0];
    assign seq_bad    = seq_wide > LAST_PC;
    assign tgt_bad    = (bus.PC_TARGET[1:0] != 2'b00) ||
                        ({1'b0, bus.PC_TARGET} > LAST_PC);
    assign instr_zero = (bus.INSTR == {reg_width{1'b0}});

    // Mutually exclusive decisions encode the RUN priority order.
    assign do_hold = bus.STALL;
    assign do_halt = !bus.STALL && instr_zero;
    assign do_jump = !bus.STALL && !instr_zero && bus.PC_SRC;
    assign do_seq  = !bus.STALL && !instr_zero && !bus.PC_SRC;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_RUN;
            a_pc       <= RESET_PC;
            halted     <= 1'b0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else if (state == S_RUN) begin
            unique case (1'b1)
                do_hold: begin
                end
                do_halt: begin
                    state  <= S_HALT;
                    halted <= 1'b1;
                end
                do_jump: begin
                    if (tgt_bad) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_addr <= bus.PC_TARGET;
                    end else begin
                        a_pc <= bus.PC_TARGET;
                    end
                end
                do_seq: begin
                    if (seq_bad) begin
                        state      <= S_FAULT;
                        fault      <= 1'b1;
                        fault_addr <= pc_plus4;
                    end else begin
                        a_pc <= pc_plus4;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.A_PC       = a_pc;
    assign bus.PC_PLUS4   = pc_plus4;
    assign bus.HALTED     = halted;
    assign bus.FAULT      = fault;
    assign bus.FAULT_ADDR = fault_addr;

`ifdef FETCH_PERF_CNT_EN
    logic        in_run;
    logic        retire;
    logic [31:0] retired_q;
    logic [31:0] cycles_q;

    assign in_run = (state == S_RUN);
    assign retire = in_run &&
                    ((do_jump && !tgt_bad) || (do_seq && !seq_bad));

    always_ff @(posedge CLK) begin
        if (RST) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            if (in_run) cycles_q <= cycles_q + 32'd1;
            if (retire) retired_q <= retired_q + 32'd1;
        end
    end

    assign bus.RETIRED = retired_q;
    assign bus.CYCLES  = cycles_q;
`else
    assign bus.RETIRED = '0;
    assign bus.CYCLES  = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl with a rule-level reference model
// compared on every falling edge plus literal checkpoints.
module tb_pc_fetch_ctrl;
    localparam int PW    = 32;
    localparam int RW    = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_fetch_ctrl_if #(.pc_width(PW), .reg_width(RW)) bus ();

    pc_fetch_ctrl #(
        .pc_width (PW),
        .reg_width(RW),
        .depth    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_fault;
    logic [31:0] m_faddr;
    logic [31:0] m_ret;
    logic [31:0] m_cyc;
    bit          started = 1'b0;

    function automatic logic [31:0] exp_cnt(logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain next-address arithmetic on unbounded integers.
    always @(posedge clk) begin : model
        longint nxt;
        if (rst) begin
            started  = 1'b1;
            m_pc     = 32'h0;
            m_halted = 1'b0;
            m_fault  = 1'b0;
            m_faddr  = 32'h0;
            m_ret    = 32'h0;
            m_cyc    = 32'h0;
        end else if (started && !m_halted && !m_fault) begin
            m_cyc = m_cyc + 1;
            if (bus.STALL) begin
            end else if (bus.INSTR == 32'h0) begin
                m_halted = 1'b1;
            end else begin
                nxt = bus.PC_SRC ? longint'(bus.PC_TARGET) : longint'(m_pc) + 4;
                if ((nxt % 4) != 0 || nxt > DEPTH * 4 - 4) begin
                    m_fault = 1'b1;
                    m_faddr = nxt[31:0];
                end else begin
                    m_pc  = nxt[31:0];
                    m_ret = m_ret + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("a_pc", bus.A_PC, m_pc);
            chk("pc_plus4", bus.PC_PLUS4, m_pc + 32'd4);
            chk("halted", {31'b0, bus.HALTED}, {31'b0, m_halted});
            chk("fault", {31'b0, bus.FAULT}, {31'b0, m_fault});
            chk("fault_addr", bus.FAULT_ADDR, m_faddr);
            chk("retired", bus.RETIRED, exp_cnt(m_ret));
            chk("cycles", bus.CYCLES, exp_cnt(m_cyc));
            chk("excl", {31'b0, bus.HALTED & bus.FAULT}, 32'h0);
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(logic [31:0] instr, bit src, logic [31:0] tgt, bit stall);
        bus.INSTR     = instr;
        bus.PC_SRC    = src;
        bus.PC_TARGET = tgt;
        bus.STALL     = stall;
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
    endtask

    initial begin
        drive(32'h93, 1'b0, 32'h0, 1'b0);
        do_reset(2);
        chk("rst_pc", bus.A_PC, 32'h0);
        chk("rst_halted", {31'b0, bus.HALTED}, 32'h0);
        chk("rst_fault", {31'b0, bus.FAULT}, 32'h0);
        chk("rst_faddr", bus.FAULT_ADDR, 32'h0);
        chk("rst_retired", bus.RETIRED, 32'h0);

        // Sequential fetch
        tick();
        chk("seq_pc4", bus.A_PC, 32'h4);
        tick();
        chk("seq_pc8", bus.A_PC, 32'h8);
        tick();
        chk("seq_pc12", bus.A_PC, 32'hC);
        chk("seq_ret3", bus.RETIRED, exp_cnt(32'd3));
        chk("seq_cyc3", bus.CYCLES, exp_cnt(32'd3));

        // Taken branch to a legal target
        do_reset(1);
        tick(2);
        drive(32'h93, 1'b1, 32'h20, 1'b0);
        tick();
        chk("br_pc", bus.A_PC, 32'h20);
        chk("br_ret", bus.RETIRED, exp_cnt(32'd3));

        // Misaligned target faults
        drive(32'h93, 1'b0, 32'h0, 1'b0);
        do_reset(1);
        tick(2);
        drive(32'h93, 1'b1, 32'h22, 1'b0);
        tick();
        chk("mis_fault", {31'b0, bus.FAULT}, 32'h1);
        chk("mis_faddr", bus.FAULT_ADDR, 32'h22);
        chk("mis_pc", bus.A_PC, 32'h8);
        drive(32'h93, 1'b1, 32'h40, 1'b0);
        tick(2);
        chk("mis_frozen", bus.A_PC, 32'h8);

        // Stall over a zero word, then halt
        drive(32'h93, 1'b0, 32'h0, 1'b0);
        do_reset(1);
        tick(4);
        chk("st_pc", bus.A_PC, 32'h10);
        drive(32'h0, 1'b0, 32'h0, 1'b1);
        tick(3);
        chk("st_hold", bus.A_PC, 32'h10);
        chk("st_nohalt", {31'b0, bus.HALTED}, 32'h0);
        chk("st_cyc", bus.CYCLES, exp_cnt(32'd7));
        drive(32'h0, 1'b0, 32'h0, 1'b0);
        tick();
        chk("halt_flag", {31'b0, bus.HALTED}, 32'h1);
        chk("halt_pc", bus.A_PC, 32'h10);

        // Everything ignored while halted
        for (int i = 0; i < 10; i++) begin
            drive((i % 2 == 0) ? 32'h0 : 32'h93 + i, i[0], 32'h40, i[1]);
            tick();
        end
        chk("hlt_pc", bus.A_PC, 32'h10);
        chk("hlt_flag", {31'b0, bus.HALTED}, 32'h1);
        chk("hlt_ret", bus.RETIRED, exp_cnt(32'd4));
        chk("hlt_cyc", bus.CYCLES, exp_cnt(32'd8));

        drive(32'h93, 1'b0, 32'h0, 1'b0);
        do_reset(1);
        chk("rel_pc", bus.A_PC, 32'h0);
        chk("rel_halted", {31'b0, bus.HALTED}, 32'h0);
        chk("rel_ret", bus.RETIRED, 32'h0);

        // Top of memory: sequential overflow
        drive(32'h93, 1'b1, 32'hF8, 1'b0);
        tick();
        chk("top_f8", bus.A_PC, 32'hF8);
        drive(32'h93, 1'b0, 32'h0, 1'b0);
        tick();
        chk("top_fc", bus.A_PC, 32'hFC);
        tick();
        chk("top_fault", {31'b0, bus.FAULT}, 32'h1);
        chk("top_faddr", bus.FAULT_ADDR, 32'h100);
        chk("top_pc", bus.A_PC, 32'hFC);

        // Out-of-range branch target
        do_reset(1);
        drive(32'h93, 1'b1, 32'h100, 1'b0);
        tick();
        chk("oor_fault", {31'b0, bus.FAULT}, 32'h1);
        chk("oor_faddr", bus.FAULT_ADDR, 32'h100);
        chk("oor_pc", bus.A_PC, 32'h0);

        // Target near top of address space
        do_reset(1);
        drive(32'h93, 1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        chk("wrap_fault", {31'b0, bus.FAULT}, 32'h1);
        chk("wrap_faddr", bus.FAULT_ADDR, 32'hFFFF_FFFC);

        drive(32'h93, 1'b0, 32'h0, 1'b0);
        do_reset(1);
        tick(2);
        chk("end_pc", bus.A_PC, 32'h8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
